cprs_3_2: RTL and testbench
===========================

Name: cprs_3_2

Overview:
- Single-column 3:2 compressor (full adder). Counts the ones in a 3-bit input column and emits a 2-bit result {carry, sum}.
- Leaf cell of the partial-product reduction trees in the bit-serial/bit-column MAC datapath.
- Instantiated many times per reduction stage.
- Default build is purely combinational. An optional output register is selectable by parameter.

Parameters:
- REG_OUT, default 0: 0 = combinational output; 1 = output registered on clk with 1-cycle latency.

Ports:
- clk  input  1  clock; used only when REG_OUT=1.
- rstn  input  1  reset, synchronous, active-low; used only when REG_OUT=1.
- in  input  3  compressor column bits in[2:0], all of equal weight.
- out  output  2  out[1] = carry (weight 2), out[0] = sum (weight 1).

Behaviour:
- Arithmetic: out = in[0] + in[1] + in[2] as an unsigned 2-bit value, range 0..3. No overflow is possible.
- Sum: out[0] = in[0] ^ in[1] ^ in[2].
- Carry: out[1] = majority(in) = (in[0]&in[1]) | (in[0]&in[2]) | (in[1]&in[2]).
- Full truth table (in -> out):
  - 000 -> 00
  - 001 -> 01
  - 010 -> 01
  - 011 -> 10
  - 100 -> 01
  - 101 -> 10
  - 110 -> 10
  - 111 -> 11
- The function is symmetric: any permutation of input bits gives the same out.
- REG_OUT=0:
  - out follows in combinationally, zero latency.
  - clk and rstn are ignored; out does not depend on reset state.
  - No latches.
- REG_OUT=1:
  - On each rising clk edge, if rstn==0 then out <= 2'b00; else out <= popcount(in).
  - Latency is exactly 1 cycle. out holds between edges.
  - Reset asserted mid-stream clears out on the next edge; the first valid result appears one edge after rstn returns high.
  - Power-up value before the first edge is unspecified; the bench must not check out before the first reset edge.
- X-propagation: any X on in produces X on the affected out bits. No X-masking logic.

Decomposition:
- No shared typedefs needed.
- A shared package may hold the constants CPRS_IN_W=3 and CPRS_OUT_W=2 for tree generators.
- No sub-module. Sum/carry logic is inline. The optional register is a single generate branch on REG_OUT.
- Higher-level trees (e.g. cprs_7_3, Wallace/Dadda stages) instantiate cprs_3_2 as the sub-module.

Test Plan:
- REG_OUT=0, sweep in = 0..7 with one step every 10 ns -> out sequence 00,01,01,10,01,10,10,11, checked 5 ns after each change.
- REG_OUT=0, counter wrap: in steps 7 -> 0 -> out goes 11 -> 00 immediately; counter keeps cycling with no stale values.
- REG_OUT=0, rstn held low while in=111 -> out=11 (reset has no effect).
- REG_OUT=1, rstn=0 for 2 edges with in=111 -> out=00. Release rstn, then at the first edge out=11.
- REG_OUT=1, sweep in=0..7 changing on negedge -> out at each posedge+1 equals popcount of the in applied before that posedge (1-cycle lag).
- REG_OUT=1, assert rstn=0 mid-sweep while in=110 -> out=00 at next edge. Deassert with in=011 -> out=10 one edge later.

Source files
------------

// File: rtl/cprs_3_2_pkg.sv
// Shared widths for the 3:2 compressor leaf cell.
// Tree generators import these rather than hard-coding column widths.
package cprs_3_2_pkg;

   localparam int CPRS_IN_W  = 3;
   localparam int CPRS_OUT_W = 2;

endpackage : cprs_3_2_pkg

// File: rtl/cprs_3_2.sv
// Single-column 3:2 compressor (full adder): out = {carry, sum} = popcount(in).
// REG_OUT selects a combinational output or a 1-cycle registered output.
module cprs_3_2
   import cprs_3_2_pkg::*;
#(
   parameter bit REG_OUT = 1'b0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [CPRS_IN_W-1:0]  in,
   output logic [CPRS_OUT_W-1:0] out
);

   logic                  sum_d;
   logic                  carry_d;
   logic [CPRS_OUT_W-1:0] out_d;

   // Plain gate equations so an X on any input reaches the affected outputs.
   assign sum_d   = in[0] ^ in[1] ^ in[2];
   assign carry_d = (in[0] & in[1]) | (in[0] & in[2]) | (in[1] & in[2]);
   assign out_d   = {carry_d, sum_d};

   generate
      if (REG_OUT) begin : g_reg_out
         logic [CPRS_OUT_W-1:0] out_q;

         always_ff @(posedge clk) begin
            if (!rstn) begin
               out_q <= '0;
            end else begin
               out_q <= out_d;
            end
         end

         assign out = out_q;
      end else begin : g_comb_out
         // Clock and reset have no role in the combinational build.
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rstn;

         assign out = out_d;
      end
   endgenerate

endmodule : cprs_3_2

// File: tb/tb_cprs_3_2.sv
// Directed bench for cprs_3_2: one combinational and one registered instance.
// Each task drives its scenario and compares against hand-computed values.
module tb_cprs_3_2;

   logic       clk;
   logic       rstn_c;
   logic       rstn_r;
   logic [2:0] in_c;
   logic [2:0] in_r;
   logic [1:0] out_c;
   logic [1:0] out_r;

   int tests_run;
   int tests_failed;

   // Hand-derived truth table: index is in[2:0], value is {carry, sum}.
   logic [1:0] exp_tab [0:7];

   cprs_3_2 #(.REG_OUT(1'b0)) dut_comb (
      .clk  (clk),
      .rstn (rstn_c),
      .in   (in_c),
      .out  (out_c)
   );

   cprs_3_2 #(.REG_OUT(1'b1)) dut_reg (
      .clk  (clk),
      .rstn (rstn_r),
      .in   (in_r),
      .out  (out_r)
   );

   // Clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      rstn_c = 1'b1;
      rstn_r = 1'b0;
      in_c   = 3'b000;
      in_r   = 3'b000;
   end

   task automatic test_reset();
      // Registered instance: reset held for two edges with all ones applied.
      @(negedge clk);
      rstn_r = 1'b0;
      in_r   = 3'b111;
      for (int e = 0; e < 2; e++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if (out_r !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_hold edge%0d: got %b expected 00", e, out_r);
         end
      end
      @(negedge clk);
      rstn_r = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (out_r !== 2'b11) begin
         tests_failed++;
         $display("FAIL reset_release: got %b expected 11", out_r);
      end
   endtask

   task automatic test_comb_sweep();
      for (int i = 0; i < 8; i++) begin
         in_c = 3'(i);
         #5;
         tests_run++;
         if (out_c !== exp_tab[i]) begin
            tests_failed++;
            $display("FAIL comb_sweep in=%b: got %b expected %b", in_c, out_c, exp_tab[i]);
         end
         #5;
      end
   endtask

   task automatic test_comb_wrap();
      in_c = 3'b111;
      #5;
      tests_run++;
      if (out_c !== 2'b11) begin
         tests_failed++;
         $display("FAIL comb_wrap_top: got %b expected 11", out_c);
      end
      // Counter keeps cycling through the wrap twice; no stale value allowed.
      for (int k = 0; k < 16; k++) begin
         in_c = 3'(k);
         #2;
         tests_run++;
         if (out_c !== exp_tab[k % 8]) begin
            tests_failed++;
            $display("FAIL comb_wrap step%0d in=%b: got %b expected %b", k, in_c, out_c, exp_tab[k % 8]);
         end
      end
   endtask

   task automatic test_comb_reset_ignored();
      rstn_c = 1'b0;
      in_c   = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (out_c !== 2'b11) begin
         tests_failed++;
         $display("FAIL comb_reset_ignored: got %b expected 11", out_c);
      end
      in_c = 3'b010;
      #1;
      tests_run++;
      if (out_c !== 2'b01) begin
         tests_failed++;
         $display("FAIL comb_reset_ignored_010: got %b expected 01", out_c);
      end
      rstn_c = 1'b1;
   endtask

   task automatic test_reg_sweep();
      logic [1:0] prev;
      prev = out_r;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_r = 3'(i);
         #1;
         // Output must not follow the input until the next edge.
         tests_run++;
         if (out_r !== prev) begin
            tests_failed++;
            $display("FAIL reg_hold in=%b: got %b expected %b", in_r, out_r, prev);
         end
         @(posedge clk);
         #1;
         tests_run++;
         if (out_r !== exp_tab[i]) begin
            tests_failed++;
            $display("FAIL reg_sweep in=%b: got %b expected %b", in_r, out_r, exp_tab[i]);
         end
         prev = exp_tab[i];
      end
   endtask

   task automatic test_reg_mid_reset();
      @(negedge clk);
      in_r = 3'b110;
      @(posedge clk);
      #1;
      tests_run++;
      if (out_r !== 2'b10) begin
         tests_failed++;
         $display("FAIL mid_reset_pre: got %b expected 10", out_r);
      end
      @(negedge clk);
      rstn_r = 1'b0;
      @(posedge clk);
      #1;
      tests_run++;
      if (out_r !== 2'b00) begin
         tests_failed++;
         $display("FAIL mid_reset_clear: got %b expected 00", out_r);
      end
      @(negedge clk);
      rstn_r = 1'b1;
      in_r   = 3'b011;
      @(posedge clk);
      #1;
      tests_run++;
      if (out_r !== 2'b10) begin
         tests_failed++;
         $display("FAIL mid_reset_release: got %b expected 10", out_r);
      end
   endtask

   task automatic test_back_to_back();
      // Permutations of one-hot and two-hot patterns must agree (symmetry).
      logic [2:0] vec [0:5];
      logic [1:0] exp [0:5];
      vec[0] = 3'b001; exp[0] = 2'b01;
      vec[1] = 3'b100; exp[1] = 2'b01;
      vec[2] = 3'b101; exp[2] = 2'b10;
      vec[3] = 3'b011; exp[3] = 2'b10;
      vec[4] = 3'b111; exp[4] = 2'b11;
      vec[5] = 3'b000; exp[5] = 2'b00;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_r = vec[i];
         in_c = vec[i];
         #1;
         tests_run++;
         if (out_c !== exp[i]) begin
            tests_failed++;
            $display("FAIL b2b_comb in=%b: got %b expected %b", vec[i], out_c, exp[i]);
         end
         @(posedge clk);
         #1;
         tests_run++;
         if (out_r !== exp[i]) begin
            tests_failed++;
            $display("FAIL b2b_reg in=%b: got %b expected %b", vec[i], out_r, exp[i]);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      exp_tab[0] = 2'b00;
      exp_tab[1] = 2'b01;
      exp_tab[2] = 2'b01;
      exp_tab[3] = 2'b10;
      exp_tab[4] = 2'b01;
      exp_tab[5] = 2'b10;
      exp_tab[6] = 2'b10;
      exp_tab[7] = 2'b11;

      test_reset();
      test_comb_sweep();
      test_comb_wrap();
      test_comb_reset_ignored();
      test_reg_sweep();
      test_reg_mid_reset();
      test_back_to_back();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_cprs_3_2
